// File: rtl/seq_divider.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor -> DW-bit quotient, VW-bit remainder.
// Latency: DW CALC cycles plus one DONE cycle after the start edge; divide-by-zero finishes in one cycle.
// Backpressure: none; start is sampled only in IDLE and ignored while busy or done.
module seq_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Working registers: quotient shift register, latched divisor, partial
  // remainder and step counter.
  logic [DW-1:0] r_q;
  logic [VW-1:0] r_d;
  logic [VW-1:0] r_r;
  logic [CW-1:0] r_cnt;

  // Result registers, loaded only when entering DONE and held afterwards.
  logic [DW-1:0] r_quotient;
  logic [VW-1:0] r_remainder;
  logic          r_div_by_zero;

  // Per-step arithmetic signals.
  logic [VW:0]   w_t;
  logic [VW:0]   w_d_ext;
  logic          w_ge;
  logic [VW-1:0] w_diff;
  logic [VW-1:0] w_r_next;
  logic [DW-1:0] w_q_next;

  // Handshake qualifiers shared by the FSM and datapath.
  logic w_accept;
  logic w_zero_div;
  logic w_last;

  assign w_accept   = (r_state == IDLE) && start;
  assign w_zero_div = (divisor == '0);
  assign w_last     = (r_state == CALC) && (r_cnt == LAST_STEP);

  // One restoring step. The trial value T is VW+1 bits wide; the partial
  // remainder is always below the divisor, so it fits in VW bits, and when
  // T >= D the difference also fits in VW bits, which makes a VW-bit modular
  // subtraction exact.
  always_comb begin
    w_t      = {r_r, r_q[DW-1]};
    w_d_ext  = {1'b0, r_d};
    w_ge     = (w_t >= w_d_ext);
    w_diff   = w_t[VW-1:0] - r_d;
    w_r_next = w_ge ? w_diff : w_t[VW-1:0];
    w_q_next = {r_q[DW-2:0], w_ge};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: zero divisor skips straight to DONE, DONE lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_zero_div ? DONE : CALC;
        end
      end
      CALC: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Working datapath: load operands on an accepted start, then shift and
  // subtract once per CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      r_d   <= '0;
      r_r   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_q   <= dividend;
      r_d   <= divisor;
      r_r   <= '0;
      r_cnt <= '0;
    end else if (r_state == CALC) begin
      r_q   <= w_q_next;
      r_r   <= w_r_next;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Result registers: written only on the transition into DONE so the
  // previous answer stays visible through IDLE and the next CALC phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else if (w_accept && w_zero_div) begin
      r_quotient    <= '1;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b1;
    end else if (w_last) begin
      r_quotient    <= w_q_next;
      r_remainder   <= w_r_next;
      r_div_by_zero <= 1'b0;
    end
  end

  assign busy        = (r_state == CALC);
  assign done        = (r_state == DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: hand-computed quotients, remainders and cycle offsets.
// Cycle k means the k-th cycle after the clock edge that samples start.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int dc, bc, dc2, bc2, done_seen;

  seq_divider #(.DW(16), .VW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one start pulse; returns at the falling edge of cycle 1.
  task automatic launch(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Starting at cycle first_k, scan until done (bounded); counts busy cycles.
  task automatic wait_done(input int first_k, output int dcyc, output int bcnt);
    dcyc = -1;
    bcnt = 0;
    for (int k = first_k; k <= 60; k++) begin
      if (busy) bcnt++;
      if (done) begin
        dcyc = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [7:0] b, output int dcyc, output int bcnt);
    launch(a, b);
    wait_done(1, dcyc, bcnt);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quot", quotient, 0);
    check("rst_rem", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst = 1'b0;

    // 1000 / 7 = 142 r 6
    run_op(16'd1000, 8'd7, dc, bc);
    check("1000_7_done_cyc", dc, 17);
    check("1000_7_busy_cnt", bc, 16);
    check("1000_7_quot", quotient, 142);
    check("1000_7_rem", remainder, 6);
    check("1000_7_dbz", div_by_zero, 0);
    check("1000_7_busy_at_done", busy, 0);
    @(negedge clk);
    check("1000_7_done_pulse", done, 0);
    @(negedge clk);
    check("1000_7_hold_quot", quotient, 142);
    check("1000_7_hold_rem", remainder, 6);

    // 65025 / 255 = 255 r 0
    run_op(16'd65025, 8'd255, dc, bc);
    check("65025_255_done_cyc", dc, 17);
    check("65025_255_quot", quotient, 255);
    check("65025_255_rem", remainder, 0);

    // 65535 / 1 = 65535 r 0
    run_op(16'd65535, 8'd1, dc, bc);
    check("65535_1_quot", quotient, 65535);
    check("65535_1_rem", remainder, 0);

    // 3 / 200 = 0 r 3
    run_op(16'd3, 8'd200, dc, bc);
    check("3_200_done_cyc", dc, 17);
    check("3_200_busy_cnt", bc, 16);
    check("3_200_quot", quotient, 0);
    check("3_200_rem", remainder, 3);

    // 5 / 0: done in cycle 1, busy never high
    run_op(16'd5, 8'd0, dc, bc);
    check("5_0_done_cyc", dc, 1);
    check("5_0_busy_cnt", bc, 0);
    check("5_0_quot", quotient, 16'hFFFF);
    check("5_0_rem", remainder, 0);
    check("5_0_dbz", div_by_zero, 1);

    // 10 / 3 = 3 r 1, clears div_by_zero
    run_op(16'd10, 8'd3, dc, bc);
    check("10_3_done_cyc", dc, 17);
    check("10_3_quot", quotient, 3);
    check("10_3_rem", remainder, 1);
    check("10_3_dbz", div_by_zero, 0);

    // start pulse with 40000/9 while busy on 1000/7 is ignored
    launch(16'd1000, 8'd7);
    repeat (4) @(negedge clk);
    dividend = 16'd40000;
    divisor  = 8'd9;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done(6, dc, bc);
    check("ign_done_cyc", dc, 17);
    check("ign_quot", quotient, 142);
    check("ign_rem", remainder, 6);
    repeat (3) @(negedge clk);
    check("ign_no_new_op", busy, 0);

    // start held high: back-to-back 10/3, one IDLE cycle between ops
    @(negedge clk);
    dividend = 16'd10;
    divisor  = 8'd3;
    start    = 1'b1;
    @(negedge clk);
    wait_done(1, dc, bc);
    check("b2b_first_done_cyc", dc, 17);
    @(negedge clk);
    wait_done(18, dc2, bc2);
    start = 1'b0;
    check("b2b_second_done_cyc", dc2, 35);
    check("b2b_second_busy_cnt", bc2, 16);
    check("b2b_quot", quotient, 3);
    check("b2b_rem", remainder, 1);

    // Leave non-zero results, then reset at CALC step 8 of a 1000/7
    run_op(16'd5, 8'd0, dc, bc);
    launch(16'd1000, 8'd7);
    repeat (7) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_quot", quotient, 0);
    check("mid_rst_rem", remainder, 0);
    check("mid_rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("aborted_no_done", done_seen, 0);

    // Fresh 100 / 10 = 10 r 0
    run_op(16'd100, 8'd10, dc, bc);
    check("100_10_done_cyc", dc, 17);
    check("100_10_quot", quotient, 10);
    check("100_10_rem", remainder, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
